// File: rtl/pulse_train_gen.sv
// pulse_train_gen
//
// Produces a programmable train of high/low periods on a single registered
// output, together with registered rising/falling edge strobes that line up
// with the edges it creates, so a downstream edge detector sampling sig on
// the same clock reports exactly the edges flagged here. A command is
// accepted with start while idle; busy covers the train and done pulses for
// one cycle at the end.
//
// Optional feature macro: PTG_ABORT_EN
//   When defined, an abort input cancels a running train at the next edge
//   without producing done.
//
// Parameters:
//   CNT_W      width of the high/low length fields
//   NUM_W      width of the pulse-count field
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   start      command strobe, sampled only in IDLE
//   high_len   high-phase length in cycles (0 treated as 1)
//   low_len    low-phase length in cycles (0 treated as 1)
//   num_pulses number of high/low periods (0 = empty command)
//   abort      cancel the running train (PTG_ABORT_EN only)
//   sig        generated waveform
//   pe         one-cycle strobe in the first cycle sig is high
//   ne         one-cycle strobe in the first cycle sig is low after a high
//   busy       train in progress
//   done       one-cycle completion strobe

module pulse_train_gen #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [NUM_W-1:0] num_pulses,
`ifdef PTG_ABORT_EN
    input  logic             abort,
`endif
    output logic             sig,
    output logic             pe,
    output logic             ne,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hl_q, hl_d;
    logic [CNT_W-1:0] ll_q, ll_d;
    logic [NUM_W-1:0] rem_q, rem_d;
    logic             sig_d, pe_d, ne_d, busy_d, done_d;
    logic [CNT_W-1:0] hl_eff, ll_eff;
    logic             abort_req;

`ifdef PTG_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // A zero length would otherwise underflow the reload value, so it is
    // promoted to a single-cycle phase before being latched.
    assign hl_eff = (high_len == '0) ? CNT_W'(1) : high_len;
    assign ll_eff = (low_len  == '0) ? CNT_W'(1) : low_len;

    // Next-state and next-output logic. Every output is computed here and
    // registered below, so sig and its strobes change on the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hl_d    = hl_q;
        ll_d    = ll_q;
        rem_d   = rem_q;
        sig_d   = sig;
        busy_d  = busy;
        pe_d    = 1'b0;
        ne_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    hl_d  = hl_eff;
                    ll_d  = ll_eff;
                    rem_d = num_pulses;
                    if (num_pulses == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = HIGH;
                        sig_d   = 1'b1;
                        pe_d    = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = hl_eff - CNT_W'(1);
                    end
                end
            end

            HIGH: begin
                if (abort_req) begin
                    // Abort wins over any phase transition; the falling edge
                    // it causes is still flagged because sig was high.
                    state_d = IDLE;
                    sig_d   = 1'b0;
                    busy_d  = 1'b0;
                    ne_d    = sig;
                    cnt_d   = '0;
                    rem_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = LOW;
                    sig_d   = 1'b0;
                    ne_d    = 1'b1;
                    cnt_d   = ll_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            LOW: begin
                if (abort_req) begin
                    state_d = IDLE;
                    sig_d   = 1'b0;
                    busy_d  = 1'b0;
                    ne_d    = sig;
                    cnt_d   = '0;
                    rem_d   = '0;
                end else if (cnt_q == '0) begin
                    if (rem_q > NUM_W'(1)) begin
                        rem_d   = rem_q - NUM_W'(1);
                        state_d = HIGH;
                        sig_d   = 1'b1;
                        pe_d    = 1'b1;
                        cnt_d   = hl_q - CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        rem_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                sig_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and all outputs. Reset is synchronous and clears
    // everything, so a mid-train reset produces neither ne nor done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hl_q    <= '0;
            ll_q    <= '0;
            rem_q   <= '0;
            sig     <= 1'b0;
            pe      <= 1'b0;
            ne      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hl_q    <= hl_d;
            ll_q    <= ll_d;
            rem_q   <= rem_d;
            sig     <= sig_d;
            pe      <= pe_d;
            ne      <= ne_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed testbench for pulse_train_gen. Each cycle the outputs are packed
// as {sig,pe,ne,busy,done} and compared against hand-computed vectors.
// Abort scenarios are included when PTG_ABORT_EN is defined.

module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic [7:0] num_pulses;
`ifdef PTG_ABORT_EN
    logic       abort;
`endif
    logic       sig, pe, ne, busy, done;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Expected {sig,pe,ne,busy,done} for cycles 1..N after the start edge.
    logic [4:0] exp_t1 [12] = '{5'b11010, 5'b10010, 5'b10010, 5'b00110,
                                5'b00010, 5'b11010, 5'b10010, 5'b10010,
                                5'b00110, 5'b00010, 5'b00001, 5'b00000};
    logic [4:0] exp_t3 [8]  = '{5'b11010, 5'b00110, 5'b11010, 5'b00110,
                                5'b11010, 5'b00110, 5'b00001, 5'b00000};
    logic [4:0] exp_t4 [11] = '{5'b11010, 5'b10010, 5'b00110, 5'b11010,
                                5'b10010, 5'b00110, 5'b00001, 5'b11010,
                                5'b00110, 5'b00001, 5'b00000};

    always #5 clk = ~clk;

    pulse_train_gen #(
        .CNT_W(8),
        .NUM_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .high_len  (high_len),
        .low_len   (low_len),
        .num_pulses(num_pulses),
`ifdef PTG_ABORT_EN
        .abort     (abort),
`endif
        .sig       (sig),
        .pe        (pe),
        .ne        (ne),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_output(input string tag, input logic [4:0] obs,
                                input logic [4:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got {sig,pe,ne,busy,done}=%b, expected %b",
                     tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic [7:0] hl,
                                  input logic [7:0] ll, input logic [7:0] n);
        start      = s;
        high_len   = hl;
        low_len    = ll;
        num_pulses = n;
    endtask

    task automatic run_cycle(input string tag, input logic [4:0] exp);
        @(posedge clk);
        #1;
        check_output(tag, {sig, pe, ne, busy, done}, exp);
    endtask

    initial begin
        rst = 1'b1;
`ifdef PTG_ABORT_EN
        abort = 1'b0;
`endif
        apply_stimulus(1'b0, 8'd0, 8'd0, 8'd0);
        @(posedge clk);
        run_cycle("reset", 5'b00000);
        rst = 1'b0;
        run_cycle("idle", 5'b00000);

        // hl=3 ll=2 N=2
        apply_stimulus(1'b1, 8'd3, 8'd2, 8'd2);
        run_cycle("t1_c1", exp_t1[0]);
        apply_stimulus(1'b0, 8'd3, 8'd2, 8'd2);
        for (int j = 1; j < 12; j++)
            run_cycle($sformatf("t1_c%0d", j + 1), exp_t1[j]);

        // empty command
        apply_stimulus(1'b1, 8'd4, 8'd4, 8'd0);
        run_cycle("t2_done", 5'b00001);
        apply_stimulus(1'b0, 8'd4, 8'd4, 8'd0);
        run_cycle("t2_after", 5'b00000);

        // zero lengths treated as 1
        apply_stimulus(1'b1, 8'd0, 8'd0, 8'd3);
        run_cycle("t3_c1", exp_t3[0]);
        apply_stimulus(1'b0, 8'd0, 8'd0, 8'd3);
        for (int j = 1; j < 8; j++)
            run_cycle($sformatf("t3_c%0d", j + 1), exp_t3[j]);

        // start ignored mid-train, then held through done
        for (int j = 1; j <= 11; j++) begin
            if (j == 1)      apply_stimulus(1'b1, 8'd2, 8'd1, 8'd2);
            else if (j == 3) apply_stimulus(1'b1, 8'd7, 8'd7, 8'd9);
            else if (j == 7) apply_stimulus(1'b1, 8'd1, 8'd1, 8'd1);
            else if (j == 9) apply_stimulus(1'b0, 8'd1, 8'd1, 8'd1);
            else if (j != 8) start = 1'b0;
            run_cycle($sformatf("t4_c%0d", j), exp_t4[j-1]);
        end

        // reset during HIGH
        apply_stimulus(1'b1, 8'd5, 8'd5, 8'd4);
        run_cycle("t5_c1", 5'b11010);
        apply_stimulus(1'b0, 8'd5, 8'd5, 8'd4);
        run_cycle("t5_c2", 5'b10010);
        run_cycle("t5_c3", 5'b10010);
        rst = 1'b1;
        run_cycle("t5_rst", 5'b00000);
        rst = 1'b0;
        for (int j = 0; j < 3; j++)
            run_cycle($sformatf("t5_post%0d", j), 5'b00000);

`ifdef PTG_ABORT_EN
        // abort in second HIGH cycle
        apply_stimulus(1'b1, 8'd4, 8'd3, 8'd2);
        run_cycle("t6_c1", 5'b11010);
        apply_stimulus(1'b0, 8'd4, 8'd3, 8'd2);
        run_cycle("t6_c2", 5'b10010);
        abort = 1'b1;
        run_cycle("t6_abort", 5'b00100);
        abort = 1'b0;
        run_cycle("t6_c4", 5'b00000);
        run_cycle("t6_c5", 5'b00000);

        // abort during LOW
        apply_stimulus(1'b1, 8'd1, 8'd3, 8'd2);
        run_cycle("t7_c1", 5'b11010);
        apply_stimulus(1'b0, 8'd1, 8'd3, 8'd2);
        run_cycle("t7_c2", 5'b00110);
        run_cycle("t7_c3", 5'b00010);
        abort = 1'b1;
        run_cycle("t7_abort", 5'b00000);
        abort = 1'b0;
        run_cycle("t7_c5", 5'b00000);

        // abort together with start in IDLE is ignored
        abort = 1'b1;
        apply_stimulus(1'b1, 8'd1, 8'd1, 8'd1);
        run_cycle("t8_c1", 5'b11010);
        abort = 1'b0;
        apply_stimulus(1'b0, 8'd1, 8'd1, 8'd1);
        run_cycle("t8_c2", 5'b00110);
        run_cycle("t8_c3", 5'b00001);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule
